// File: rtl/bus_arb_pkg.sv
// Shared definitions for the N-master bus arbiter.
// Holds the slave response codes, the arbiter state encoding and a helper
// that sizes the master-index field.
package bus_arb_pkg;

    // Slave response codes carried on HRESP
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    // Arbiter control states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width of a master index; never narrower than one bit
    function automatic int mid_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// Request/grant bundle between the bus masters, the slaves and the arbiter.
//   HREQ/HLOCK/HSPLIT : per-master request, lock request, split release
//   HRESP/HREADY      : response and completion of the current transfer
//   HGRANT/HMAS/MLOCK/BUSY : arbitration result
// Modport 'master' is the arbitration side (it masters the grant lines);
// modport 'slave' is the requester/bus side that consumes the grants.
interface bus_arbiter_n_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MID_W       = mid_w(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] HREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [NUM_MASTERS-1:0] HSPLIT;
    logic [1:0]             HRESP;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MID_W-1:0]       HMAS;
    logic                   MLOCK;
    logic                   BUSY;

    modport master (
        input  HREQ, HLOCK, HSPLIT, HRESP, HREADY,
        output HGRANT, HMAS, MLOCK, BUSY
    );

    modport slave (
        output HREQ, HLOCK, HSPLIT, HRESP, HREADY,
        input  HGRANT, HMAS, MLOCK, BUSY
    );
endinterface

// File: rtl/bus_arbiter_n_rr_pick.sv
// Rotating-priority search (purely combinational).
//   req_i   : candidate request vector
//   start_i : index searched first; search wraps modulo N
//   gnt_o   : one-hot winner, zero when no request
//   idx_o   : index of the winner, zero when no request
//   valid_o : at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [N-1:0]  gnt_s;
    logic [IW-1:0] idx_s;
    logic [IW-1:0] pos_s;
    logic          found_s;

    // First requester at or after start_i, wrapping around
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        pos_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s = IW'((int'(start_i) + k) % N);
            if (!found_s && req_i[pos_s]) begin
                found_s       = 1'b1;
                gnt_s[pos_s]  = 1'b1;
                idx_s         = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_o   = gnt_s;
    assign idx_o   = idx_s;
    assign valid_o = found_s;

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with locked transfers, hold-time limit and
// optional split support.
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset
//   bus    : bus_arbiter_n_if.master (requests in, grant/HMAS/MLOCK/BUSY out)
// Optional feature: define ARB_SPLIT_EN to mask a master that receives a
// SPLIT response until its HSPLIT bit releases it; without it SPLIT acts
// like RETRY and HSPLIT is ignored.
// All outputs come straight from flops.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int MID_W       = mid_w(NUM_MASTERS)
) (
    input  logic              CLK,
    input  logic              RST,
    bus_arbiter_n_if.master   bus
);

    localparam int N     = NUM_MASTERS;
    localparam int CNT_W = $clog2(MAX_HOLD + 2);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [MID_W-1:0] owner_q, owner_d;
    logic [MID_W-1:0] last_owner_q, last_owner_d;
    logic             mlock_q, mlock_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     split_mask_q, split_mask_d;
    logic [N-1:0]     rel_pend_q, rel_pend_d;

    logic [N-1:0]     eligible_s;
    logic             rsp_rel_s;
    logic             owner_lock_s;
    logic             owner_req_s;
    logic             others_s;
    logic             hold_hit_s;
    logic             release_s;
    logic             excl_s;
    logic [N-1:0]     cand_s;
    logic [N-1:0]     released_s;
    logic [N-1:0]     locked_s;
    logic [N-1:0]     class_s;
    logic [MID_W-1:0] start_s;
    logic [N-1:0]     pick_oh_s;
    logic [MID_W-1:0] pick_idx_s;
    logic             pick_vld_s;
    logic [N-1:0]     new_oh_s;

    assign eligible_s   = bus.HREQ & ~split_mask_q;
    assign rsp_rel_s    = (state_q == ST_GRANT) && bus.HREADY &&
                          ((bus.HRESP == RESP_RETRY) || (bus.HRESP == RESP_SPLIT));
    assign owner_lock_s = |(bus.HLOCK & grant_q);
    assign owner_req_s  = |(bus.HREQ & grant_q);
    assign others_s     = |(eligible_s & ~grant_q);
    assign hold_hit_s   = (MAX_HOLD != 0) && (hold_cnt_q >= CNT_W'(MAX_HOLD));

    // Release decision for the current owner; excl_s keeps it out of the
    // same-cycle re-arbitration when it is forced off the bus
    always_comb begin
        release_s = 1'b0;
        excl_s    = 1'b0;
        if (state_q == ST_GRANT) begin
            if (rsp_rel_s) begin
                release_s = 1'b1;
                excl_s    = 1'b1;
            end else if (!bus.HREADY || owner_lock_s) begin
                release_s = 1'b0;
                excl_s    = 1'b0;
            end else if (!owner_req_s) begin
                release_s = 1'b1;
                excl_s    = 1'b0;
            end else if (hold_hit_s && others_s) begin
                release_s = 1'b1;
                excl_s    = 1'b1;
            end else begin
                release_s = 1'b0;
                excl_s    = 1'b0;
            end
        end else begin
            release_s = 1'b0;
            excl_s    = 1'b0;
        end
    end

    assign cand_s     = excl_s ? (eligible_s & ~grant_q) : eligible_s;
    assign released_s = cand_s & rel_pend_q;
    assign locked_s   = cand_s & bus.HLOCK;
    assign start_s    = (last_owner_q == MID_W'(N - 1)) ? MID_W'(0)
                                                         : (last_owner_q + MID_W'(1));

    // Priority classes: split-released, then locked, then everyone;
    // the round-robin search breaks ties inside the chosen class
    always_comb begin
        class_s = cand_s;
        if (|released_s) begin
            class_s = released_s;
        end else if (|locked_s) begin
            class_s = locked_s;
        end else begin
            class_s = cand_s;
        end
    end

    rr_pick #(
        .N  (N),
        .IW (MID_W)
    ) u_rr_pick (
        .req_i   (class_s),
        .start_i (start_s),
        .gnt_o   (pick_oh_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_vld_s)
    );

    assign new_oh_s = (((state_q == ST_IDLE) || release_s) && pick_vld_s) ? pick_oh_s : '0;

    // Next-state and output computation for the IDLE/GRANT controller
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mlock_d      = mlock_q;
        busy_d       = busy_q;
        hold_cnt_d   = hold_cnt_q;
        case (state_q)
            ST_IDLE, ST_GRANT: begin
                if ((state_q == ST_IDLE) || release_s) begin
                    if (pick_vld_s) begin
                        state_d      = ST_GRANT;
                        grant_d      = pick_oh_s;
                        owner_d      = pick_idx_s;
                        last_owner_d = pick_idx_s;
                        mlock_d      = |(bus.HLOCK & pick_oh_s);
                        busy_d       = 1'b1;
                        hold_cnt_d   = CNT_W'(1);
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        owner_d    = '0;
                        mlock_d    = 1'b0;
                        busy_d     = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else begin
                    // Owner keeps the bus; tenure only advances on completed beats
                    mlock_d = owner_lock_s;
                    if (bus.HREADY && (hold_cnt_q < CNT_W'(MAX_HOLD))) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                owner_d    = '0;
                mlock_d    = 1'b0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

`ifdef ARB_SPLIT_EN
    logic [N-1:0] split_set_s;

    // Split bookkeeping: a set wins over a same-cycle clear; a master freed
    // by HSPLIT stays in the top priority class until it is granted
    always_comb begin
        split_set_s = '0;
        if ((state_q == ST_GRANT) && bus.HREADY && (bus.HRESP == RESP_SPLIT)) begin
            split_set_s = grant_q;
        end else begin
            split_set_s = '0;
        end
        split_mask_d = (split_mask_q & ~bus.HSPLIT) | split_set_s;
        rel_pend_d   = (rel_pend_q | (bus.HSPLIT & split_mask_q)) & ~split_set_s & ~new_oh_s;
    end
`else
    logic unused_split_s;
    assign unused_split_s = (^bus.HSPLIT) ^ (^new_oh_s);

    // Split support compiled out: mask and release tracking stay clear
    always_comb begin
        split_mask_d = '0;
        rel_pend_d   = '0;
    end
`endif

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= MID_W'(N - 1);
            mlock_q      <= 1'b0;
            busy_q       <= 1'b0;
            hold_cnt_q   <= '0;
            split_mask_q <= '0;
            rel_pend_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mlock_q      <= mlock_d;
            busy_q       <= busy_d;
            hold_cnt_q   <= hold_cnt_d;
            split_mask_q <= split_mask_d;
            rel_pend_q   <= rel_pend_d;
        end
    end

    assign bus.HGRANT = grant_q;
    assign bus.HMAS   = owner_q;
    assign bus.MLOCK  = mlock_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
module tb_bus_arbiter_n;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bus_arbiter_n_if #(.NUM_MASTERS(4), .MID_W(2)) bif ();

    bus_arbiter_n #(
        .NUM_MASTERS (4),
        .MAX_HOLD    (2),
        .MID_W       (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                         input logic [1:0] resp, input logic rdy);
        bif.HREQ   = req;
        bif.HLOCK  = lock;
        bif.HRESP  = resp;
        bif.HREADY = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        tick();
        tick();
        total++;
        if (bif.HGRANT !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bif.HGRANT); end
        total++;
        if (bif.HMAS !== 2'd0) begin bad++; $display("FAIL reset_hmas got=%0d exp=0", bif.HMAS); end
        total++;
        if ({bif.MLOCK, bif.BUSY} !== 2'b00) begin bad++; $display("FAIL reset_mlock_busy got=%b exp=00", {bif.MLOCK, bif.BUSY}); end
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        rst = 1'b0;
        tick();
        total++;
        if (bif.BUSY !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", bif.BUSY); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [10];
        logic [1:0] exp_m [10];
        exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        exp_m = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bif.HGRANT !== exp_g[i] || bif.HMAS !== exp_m[i] || bif.BUSY !== 1'b1) begin
                bad++;
                $display("FAIL rr_tenure cycle=%0d got=%b/%0d/%b exp=%b/%0d/1", i, bif.HGRANT, bif.HMAS, bif.BUSY, exp_g[i], exp_m[i]);
            end
        end
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0000 || bif.BUSY !== 1'b0) begin bad++; $display("FAIL rr_to_idle got=%b busy=%b exp=0000 busy=0", bif.HGRANT, bif.BUSY); end
    endtask

    task automatic test_lock_hold();
        drive(4'b0100, 4'b0100, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0100 || bif.MLOCK !== 1'b1) begin bad++; $display("FAIL lock_first got=%b mlock=%b exp=0100 mlock=1", bif.HGRANT, bif.MLOCK); end
        drive(4'b1111, 4'b0100, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bif.HGRANT !== 4'b0100 || bif.MLOCK !== 1'b1) begin bad++; $display("FAIL lock_hold cycle=%0d got=%b mlock=%b exp=0100 mlock=1", i, bif.HGRANT, bif.MLOCK); end
        end
        drive(4'b1111, 4'b0000, 2'b00, 1'b0);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0100 || bif.MLOCK !== 1'b0) begin bad++; $display("FAIL unlock_wait got=%b mlock=%b exp=0100 mlock=0", bif.HGRANT, bif.MLOCK); end
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b1000 || bif.HMAS !== 2'd3) begin bad++; $display("FAIL unlock_release got=%b/%0d exp=1000/3", bif.HGRANT, bif.HMAS); end
    endtask

    task automatic test_hready_stall();
        drive(4'b1111, 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bif.HGRANT !== 4'b1000) begin bad++; $display("FAIL stall_hold cycle=%0d got=%b exp=1000", i, bif.HGRANT); end
        end
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b1000) begin bad++; $display("FAIL stall_no_count got=%b exp=1000", bif.HGRANT); end
        tick();
        total++;
        if (bif.HGRANT !== 4'b0001 || bif.HMAS !== 2'd0) begin bad++; $display("FAIL stall_release got=%b/%0d exp=0001/0", bif.HGRANT, bif.HMAS); end
    endtask

    task automatic test_retry_release();
        drive(4'b1111, 4'b0000, 2'b10, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0010) begin bad++; $display("FAIL retry_release got=%b exp=0010", bif.HGRANT); end
        drive(4'b0001, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0001) begin bad++; $display("FAIL retry_reeligible got=%b exp=0001", bif.HGRANT); end
        drive(4'b0011, 4'b0001, 2'b10, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0010 || bif.MLOCK !== 1'b0) begin bad++; $display("FAIL retry_overrides_lock got=%b mlock=%b exp=0010 mlock=0", bif.HGRANT, bif.MLOCK); end
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.BUSY !== 1'b0 || bif.HMAS !== 2'd0) begin bad++; $display("FAIL retry_to_idle busy=%b hmas=%0d exp busy=0 hmas=0", bif.BUSY, bif.HMAS); end
    endtask

    task automatic test_lock_priority();
        drive(4'b1101, 4'b1000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b1000 || bif.MLOCK !== 1'b1) begin bad++; $display("FAIL lock_priority got=%b mlock=%b exp=1000 mlock=1", bif.HGRANT, bif.MLOCK); end
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0000 || bif.BUSY !== 1'b0) begin bad++; $display("FAIL lock_priority_idle got=%b busy=%b exp=0000 busy=0", bif.HGRANT, bif.BUSY); end
    endtask

`ifndef ARB_SPLIT_EN
    task automatic test_split_as_retry();
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0001) begin bad++; $display("FAIL split_setup got=%b exp=0001", bif.HGRANT); end
        drive(4'b1111, 4'b0000, 2'b11, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0010 || bif.HMAS !== 2'd1) begin bad++; $display("FAIL split_next_owner got=%b/%0d exp=0010/1", bif.HGRANT, bif.HMAS); end
        drive(4'b0001, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0001) begin bad++; $display("FAIL split_not_masked got=%b exp=0001", bif.HGRANT); end
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        tick();
    endtask
`endif

    task automatic test_reset_mid_lock();
        drive(4'b0001, 4'b0001, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0001 || bif.MLOCK !== 1'b1) begin bad++; $display("FAIL rst_setup got=%b mlock=%b exp=0001 mlock=1", bif.HGRANT, bif.MLOCK); end
        rst = 1'b1;
        tick();
        total++;
        if ({bif.HGRANT, bif.HMAS, bif.MLOCK, bif.BUSY} !== 8'b0) begin
            bad++;
            $display("FAIL rst_mid_lock got=%b/%0d/%b/%b exp=all zero", bif.HGRANT, bif.HMAS, bif.MLOCK, bif.BUSY);
        end
        rst = 1'b0;
        drive(4'b0110, 4'b0000, 2'b00, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0010 || bif.HMAS !== 2'd1) begin bad++; $display("FAIL rst_first_grant got=%b/%0d exp=0010/1", bif.HGRANT, bif.HMAS); end
    endtask

`ifdef ARB_SPLIT_EN
    task automatic test_split_mask();
        drive(4'b1111, 4'b0000, 2'b11, 1'b1);
        tick();
        total++;
        if (bif.HGRANT !== 4'b0100) begin bad++; $display("FAIL split_en_next got=%b exp=0100", bif.HGRANT); end
        drive(4'b1111, 4'b0000, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bif.HGRANT[1] !== 1'b0) begin bad++; $display("FAIL split_masked cycle=%0d got=%b exp bit1=0", i, bif.HGRANT); end
        end
        bif.HSPLIT = 4'b0010;
        tick();
        total++;
        if (bif.HGRANT !== 4'b0100) begin bad++; $display("FAIL split_release_hold got=%b exp=0100", bif.HGRANT); end
        bif.HSPLIT = 4'b0000;
        tick();
        total++;
        if (bif.HGRANT !== 4'b0010) begin bad++; $display("FAIL split_released_first got=%b exp=0010", bif.HGRANT); end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bif.HSPLIT = 4'b0000;
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        test_reset();
        test_round_robin();
        test_lock_hold();
        test_hready_stall();
        test_retry_release();
        test_lock_priority();
`ifndef ARB_SPLIT_EN
        test_split_as_retry();
`endif
        test_reset_mid_lock();
`ifdef ARB_SPLIT_EN
        test_split_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
